// File: rtl/ad9363_tx_pkg.sv
// Shared definitions for the AD9363 TX sample feeder.
//   IQ_W          default I/Q sample width
//   tx_state_e    feeder FSM states
//   entry_width() width of one packed FIFO entry {tlast, I, Q}
package ad9363_tx_pkg;

  localparam int unsigned IQ_W = 12;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StRun  = 2'd2
  } tx_state_e;

  function automatic int unsigned entry_width(input int unsigned data_w);
    return 2 * data_w + 1;
  endfunction

endpackage

// File: rtl/ad9363_tx_sfifo.sv
// Synchronous single-clock FIFO with a registered read port.
//   data_clk, rst  clock and asynchronous active-high reset
//   flush          empties the FIFO; overrides any read or write that cycle
//   wr_en/wr_data  push (ignored when full)
//   rd_en/rd_data  pop (ignored when empty); rd_data updates the cycle after a pop
//                  and holds otherwise
//   head_last      msb of the entry at the head, valid while not empty
//   level          occupancy; full/empty derived from it
module ad9363_tx_sfifo #(
  parameter int unsigned Width  = 25,
  parameter int unsigned Depth  = 16,
  localparam int unsigned AddrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned LevelW = $clog2(Depth + 1)
) (
  input  logic              data_clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [Width-1:0]  wr_data,
  input  logic              rd_en,
  output logic [Width-1:0]  rd_data,
  output logic              head_last,
  output logic [LevelW-1:0] level,
  output logic              full,
  output logic              empty
);

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [Width-1:0]  rd_data_q, rd_data_d;
  logic              wr_fire, rd_fire;

  assign full    = (level_q == LevelW'(Depth));
  assign empty   = (level_q == '0);
  assign wr_fire = wr_en && !full && !flush;
  assign rd_fire = rd_en && !empty && !flush;

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + AddrW'(1);
      end
      if (rd_fire) begin
        rd_ptr_d  = rd_ptr_q + AddrW'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      level_d = level_q + LevelW'(wr_fire) - LevelW'(rd_fire);
    end
  end

  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset; level gates every read of it.
  always_ff @(posedge data_clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign head_last = mem_q[rd_ptr_q][Width-1];
  assign level     = level_q;

endmodule

// File: rtl/ad9363_tx_sample_feeder.sv
// AD9363 TX sample feeder: buffers AXI-Stream IQ samples and paces them out to the
// TX PHY in the data_clk domain, with burst prefill, end-of-burst, underrun
// zero-stuffing and status counters.
//   data_clk, rst         clock and asynchronous active-high reset
//   tx_en                 enable; low flushes the FIFO and forces idle
//   s_axis_*              input stream, tdata = {I, Q}, tlast ends a burst
//   dac_valid, dac_data_* one-cycle strobe per emitted sample and its I/Q
//   fifo_level            FIFO occupancy
//   underrun(_cnt)        sticky flag and saturating count of underrun slots
//   clr_status            synchronous clear of the underrun status
module ad9363_tx_sample_feeder
  import ad9363_tx_pkg::*;
#(
  parameter int unsigned DATA_W      = IQ_W,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned START_LEVEL = 8,
  parameter int unsigned RATE_DIV    = 1,
  localparam int unsigned LevelW     = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned EntryW     = entry_width(DATA_W)
) (
  input  logic                data_clk,
  input  logic                rst,
  input  logic                tx_en,
  input  logic [2*DATA_W-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic                dac_valid,
  output logic [DATA_W-1:0]   dac_data_i1,
  output logic [DATA_W-1:0]   dac_data_q1,
  output logic [LevelW-1:0]   fifo_level,
  output logic                underrun,
  output logic [15:0]         underrun_cnt,
  input  logic                clr_status
);

  tx_state_e         state_q, state_d;
  logic [7:0]        rate_cnt_q, rate_cnt_d;
  logic [LevelW-1:0] last_cnt_q, last_cnt_d;
  logic              dac_valid_q, dac_valid_d;
  logic              zero_q, zero_d;
  logic              underrun_q, underrun_d;
  logic [15:0]       underrun_cnt_q, underrun_cnt_d;

  logic              flush, wr_en, rd_en, slot;
  logic              fifo_full, fifo_empty, head_last;
  logic [LevelW-1:0] level;
  logic [EntryW-1:0] rd_entry;
  logic              unused_rd_last;

  assign s_axis_tready = (state_q != StIdle) && !fifo_full;
  assign wr_en         = s_axis_tvalid && s_axis_tready;
  assign slot          = (state_q == StRun) && (rate_cnt_q == 8'd0);

  ad9363_tx_sfifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .data_clk  (data_clk),
    .rst       (rst),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_data   ({s_axis_tlast, s_axis_tdata}),
    .rd_en     (rd_en),
    .rd_data   (rd_entry),
    .head_last (head_last),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d        = state_q;
    rate_cnt_d     = 8'd0;
    last_cnt_d     = last_cnt_q;
    dac_valid_d    = 1'b0;
    zero_d         = zero_q;
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;
    flush          = 1'b0;
    rd_en          = 1'b0;

    if (!tx_en) begin
      state_d = StIdle;
      flush   = 1'b1;
      zero_d  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          flush   = 1'b1;
          state_d = StFill;
        end
        StFill: begin
          if (level >= LevelW'(START_LEVEL) || last_cnt_q != '0) begin
            state_d = StRun;
          end
        end
        StRun: begin
          rate_cnt_d = (rate_cnt_q == 8'(RATE_DIV - 1)) ? 8'd0 : rate_cnt_q + 8'd1;
          if (slot) begin
            dac_valid_d = 1'b1;
            if (!fifo_empty) begin
              rd_en  = 1'b1;
              zero_d = 1'b0;
              if (head_last) begin
                state_d = StFill;
              end
            end else begin
              // Underrun: emit a zero sample and keep running.
              zero_d     = 1'b1;
              underrun_d = 1'b1;
              if (underrun_cnt_q != 16'hFFFF) begin
                underrun_cnt_d = underrun_cnt_q + 16'd1;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (flush) begin
      last_cnt_d = '0;
    end else begin
      last_cnt_d = last_cnt_q + LevelW'(wr_en && s_axis_tlast) - LevelW'(rd_en && head_last);
    end

    if (clr_status) begin
      underrun_d     = 1'b0;
      underrun_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      rate_cnt_q     <= 8'd0;
      last_cnt_q     <= '0;
      dac_valid_q    <= 1'b0;
      zero_q         <= 1'b1;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      rate_cnt_q     <= rate_cnt_d;
      last_cnt_q     <= last_cnt_d;
      dac_valid_q    <= dac_valid_d;
      zero_q         <= zero_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  // The FIFO read register holds between pops, so the data outputs hold too;
  // zero_q forces zeros after an underrun slot, an abort or reset.
  assign dac_valid      = dac_valid_q;
  assign dac_data_i1    = zero_q ? '0 : rd_entry[2*DATA_W-1:DATA_W];
  assign dac_data_q1    = zero_q ? '0 : rd_entry[DATA_W-1:0];
  assign fifo_level     = level;
  assign underrun       = underrun_q;
  assign underrun_cnt   = underrun_cnt_q;
  assign unused_rd_last = rd_entry[EntryW-1];

endmodule

// File: tb/tb_ad9363_tx_sample_feeder.sv
module tb_ad9363_tx_sample_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: default parameters. Instance B: START_LEVEL=16, RATE_DIV=4.
  logic        a_en, a_tvalid, a_tlast, a_clr, a_tready, a_valid, a_under;
  logic [23:0] a_tdata;
  logic [11:0] a_i, a_q;
  logic [4:0]  a_level;
  logic [15:0] a_cnt;
  logic        b_en, b_tvalid, b_tlast, b_clr, b_tready, b_valid, b_under;
  logic [23:0] b_tdata;
  logic [11:0] b_i, b_q;
  logic [4:0]  b_level;
  logic [15:0] b_cnt;

  ad9363_tx_sample_feeder #(
    .DATA_W(12), .FIFO_DEPTH(16), .START_LEVEL(8), .RATE_DIV(1)
  ) u_dut_a (
    .data_clk(clk), .rst(rst), .tx_en(a_en), .s_axis_tdata(a_tdata),
    .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready), .s_axis_tlast(a_tlast),
    .dac_valid(a_valid), .dac_data_i1(a_i), .dac_data_q1(a_q), .fifo_level(a_level),
    .underrun(a_under), .underrun_cnt(a_cnt), .clr_status(a_clr)
  );

  ad9363_tx_sample_feeder #(
    .DATA_W(12), .FIFO_DEPTH(16), .START_LEVEL(16), .RATE_DIV(4)
  ) u_dut_b (
    .data_clk(clk), .rst(rst), .tx_en(b_en), .s_axis_tdata(b_tdata),
    .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready), .s_axis_tlast(b_tlast),
    .dac_valid(b_valid), .dac_data_i1(b_i), .dac_data_q1(b_q), .fifo_level(b_level),
    .underrun(b_under), .underrun_cnt(b_cnt), .clr_status(b_clr)
  );

  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors / scoreboard ----------------
  int a_strobes = 0, a_run = 0, a_max_run = 0;
  always @(negedge clk) begin
    if (a_valid) begin
      a_strobes++;
      a_run++;
      if (a_run > a_max_run) a_max_run = a_run;
      if (exp_a.size() == 0) timeout("a_unexpected_strobe");
      else chk("a_data", {8'h0, a_i, a_q}, {8'h0, exp_a.pop_front()});
    end else begin
      a_run = 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int b_strobes = 0;
  int b_last_cyc = -100;
  logic [23:0] b_last = '0;
  always @(negedge clk) begin
    if (b_valid) begin
      b_strobes++;
      if (cyc - b_last_cyc < 8) chk("b_interval", cyc - b_last_cyc, 4);
      b_last_cyc = cyc;
      if (exp_b.size() == 0) timeout("b_unexpected_strobe");
      else chk("b_data", {8'h0, b_i, b_q}, {8'h0, exp_b.pop_front()});
      b_last = {b_i, b_q};
    end else begin
      chk("b_hold", {8'h0, b_i, b_q}, {8'h0, b_last});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input bit sel, input logic [11:0] i, input logic [11:0] q, input bit last);
    bit r;
    int n;
    if (!sel) begin
      a_tdata = {i, q}; a_tlast = last; a_tvalid = 1'b1;
    end else begin
      b_tdata = {i, q}; b_tlast = last; b_tvalid = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      r = sel ? b_tready : a_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 64);
    if (!r) timeout("push_accept");
    else if (!sel) exp_a.push_back({i, q});
    else exp_b.push_back({i, q});
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
  endtask

  // Returns at negedge+1 of the cycle in which the last expected strobe was seen.
  task automatic wait_empty(input bit sel, input int bound, input string name);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      #1;
      if ((sel ? exp_b.size() : exp_a.size()) == 0) return;
    end
    timeout(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int lvl;
    bit hit;
    rst = 1'b1;
    {a_en, a_tvalid, a_tlast, a_clr, a_tdata} = '0;
    {b_en, b_tvalid, b_tlast, b_clr, b_tdata} = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", {a_i, a_q}, 0);
    chk("rst_level", a_level, 0);
    chk("rst_underrun", a_under, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_tready", a_tready, 0);

    // 1. Basic stream: 8 prefill then 24 back-to-back, tlast on the 32nd
    tick();
    a_en = 1'b1;
    tick();
    tick();
    for (int n = 0; n < 8; n++) push(0, 12'(n), 12'(-n), 0);
    @(negedge clk);
    chk("t1_prefill_level", a_level, 8);
    chk("t1_no_early_strobe", a_strobes, 0);
    tick();
    for (int n = 8; n < 32; n++) push(0, 12'(n), 12'(-n), n == 31);
    wait_empty(0, 100, "t1_drain");
    repeat (5) tick();
    chk("t1_continuous_run", a_max_run, 32);
    chk("t1_underrun", a_under, 0);

    // 2. Short burst of 3 with tlast
    s0 = a_strobes;
    for (int k = 0; k < 3; k++) push(0, 12'(100 + k), 12'(200 + k), k == 2);
    wait_empty(0, 40, "t2_drain");
    repeat (10) tick();
    chk("t2_strobes", a_strobes - s0, 3);
    chk("t2_underrun", a_under, 0);
    chk("t2_level", a_level, 0);

    // 3. Underrun: 8 samples then 5 zero-stuffed slots, then abort and clear
    for (int k = 0; k < 8; k++) push(0, 12'(300 + k), 12'(k), 0);
    for (int k = 0; k < 5; k++) exp_a.push_back(24'h0);
    wait_empty(0, 60, "t3_drain");
    a_en = 1'b0;
    @(negedge clk);
    chk("t3_underrun", a_under, 1);
    chk("t3_cnt", a_cnt, 5);
    tick();
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    @(negedge clk);
    chk("t3_clr_cnt", a_cnt, 0);
    chk("t3_clr_underrun", a_under, 0);

    // 6. Abort mid-RUN at level 6
    tick();
    a_en = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 8; k++) push(0, 12'(400 + k), 12'(50 + k), 0);
    hit = 0;
    for (int n = 0; n < 30 && !hit; n++) begin
      @(negedge clk);
      #1;
      if (a_level == 5'd6) hit = 1;
    end
    if (!hit) timeout("t6_level6");
    a_en = 1'b0;
    @(negedge clk);
    chk("t6_valid", a_valid, 0);
    chk("t6_data", {a_i, a_q}, 0);
    chk("t6_level", a_level, 0);
    chk("t6_tready", a_tready, 0);
    chk("t6_emitted_before_abort", exp_a.size(), 6);
    exp_a.delete();
    tick();
    a_en = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) push(0, 12'(500 + k), 12'(k), 0);
    repeat (10) tick();
    chk("t6_fresh_prefill_level", a_level, 3);
    for (int k = 3; k < 8; k++) push(0, 12'(500 + k), 12'(k), k == 7);
    wait_empty(0, 60, "t6_drain");

    // 4. Rate pacing on B: 8 samples ending in tlast, one pop per 4 cycles
    b_en = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 8; k++) push(1, 12'(600 + k), 12'(k + 1), k == 7);
    hit = 0;
    for (int n = 0; n < 30 && !hit; n++) begin
      @(negedge clk);
      #1;
      if (b_strobes == 1) hit = 1;
    end
    if (!hit) timeout("t4_first_strobe");
    lvl = int'(b_level);
    chk("t4_level_first", lvl, 7);
    repeat (4) @(negedge clk);
    chk("t4_level_drain", b_level, 5'(lvl - 1));
    wait_empty(1, 80, "t4_drain");

    // 5. Backpressure on B: 20 samples into a 16-deep FIFO held in FILL
    repeat (3) tick();
    for (int k = 0; k < 16; k++) push(1, 12'(700 + k), 12'(3 * k), 0);
    @(negedge clk);
    chk("t5_tready_full", b_tready, 0);
    chk("t5_level_full", b_level, 16);
    tick();
    for (int k = 16; k < 20; k++) push(1, 12'(700 + k), 12'(3 * k), k == 19);
    wait_empty(1, 200, "t5_drain");
    repeat (10) tick();
    chk("t5_underrun", b_under, 0);
    chk("t5_strobes", b_strobes, 28);

    repeat (5) tick();
    chk("end_queue_a", exp_a.size(), 0);
    chk("end_queue_b", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
